// File: rtl/piano_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : piano_cfg_pkg
//  Description : Shared configuration for the piano key bank: default channel
//                count, 1 ms tick divider at 50 MHz, repeat FSM state encoding
//                and a counter-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package piano_cfg_pkg;

    localparam int NUM_KEYS_DEFAULT = 8;
    localparam int TICK_DIV_1MS     = 50000;

    // Hold-to-repeat state per channel.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RPT  = 2'd2
    } rpt_state_t;

    // Width of a counter that must reach max_count-1, never narrower than 1 bit.
    function automatic int cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce_chan.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce_chan
//  Description : One key channel: polarity mapping, 2-FF synchroniser,
//                tick-based debounce counter, press/release pulses and the
//                hold-to-repeat FSM.
//  Ports       : clk, rst_n      clock, async active-low reset
//                i_key_raw       raw asynchronous key pin
//                i_tick          shared debounce tick (1-cycle strobe)
//                i_repeat_en     enables hold-to-repeat pulses
//                o_level         debounced level, 1 = pressed
//                o_press         1-cycle pulse on debounced 0->1
//                o_release       1-cycle pulse on debounced 1->0
//                o_repeat        1-cycle pulse per repeat interval while held
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce_chan
    import piano_cfg_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 20,
    parameter int HOLD_TICKS     = 500,
    parameter int REPEAT_TICKS   = 100,
    parameter bit ACTIVE_LOW     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key_raw,
    input  logic i_tick,
    input  logic i_repeat_en,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_repeat
);

    localparam int c_DB_W     = cnt_width(DEBOUNCE_TICKS);
    localparam int c_HOLD_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int c_HOLD_W   = cnt_width(c_HOLD_MAX);

    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_TICKS - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_TICKS - 1);
    localparam logic [c_HOLD_W-1:0] c_RPT_LAST  = c_HOLD_W'(REPEAT_TICKS - 1);

    logic                r_sync1;
    logic                r_sync2;
    logic                r_level;
    logic [c_DB_W-1:0]   r_db_cnt;
    logic                r_press;
    logic                r_release;
    logic                r_repeat;
    rpt_state_t          r_state;
    logic [c_HOLD_W-1:0] r_hold_cnt;

    logic w_key_mapped;
    logic w_mismatch;
    logic w_accept;
    logic w_press_evt;
    logic w_release_evt;

    // Inversion happens before the synchroniser so the flops always reset
    // to 0, which is "released" for either pin polarity.
    assign w_key_mapped  = ACTIVE_LOW ? ~i_key_raw : i_key_raw;
    assign w_mismatch    = r_sync2 ^ r_level;
    assign w_accept      = w_mismatch & i_tick & (r_db_cnt == c_DB_LAST);
    assign w_press_evt   = w_accept & ~r_level;
    assign w_release_evt = w_accept &  r_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= w_key_mapped;
            r_sync2 <= r_sync1;
        end
    end

    // Any cycle where the synchronised input agrees with the accepted level
    // restarts the count, so a glitch shorter than the window is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level   <= 1'b0;
            r_db_cnt  <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= w_press_evt;
            r_release <= w_release_evt;
            if (!w_mismatch) begin
                r_db_cnt <= '0;
            end else if (i_tick) begin
                if (r_db_cnt == c_DB_LAST) begin
                    r_level  <= ~r_level;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + c_DB_W'(1);
                end
            end
        end
    end

    // The FSM reacts to the press/release events in the same edge that the
    // level changes, so hold timing starts exactly at the acceptance tick and
    // a repeat can never land on the press cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= '0;
            r_repeat   <= 1'b0;
        end else begin
            r_repeat <= 1'b0;
            if (!i_repeat_en || w_release_evt) begin
                r_state    <= ST_IDLE;
                r_hold_cnt <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_hold_cnt <= '0;
                        if (w_press_evt) begin
                            r_state <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (i_tick) begin
                            if (r_hold_cnt == c_HOLD_LAST) begin
                                r_repeat   <= 1'b1;
                                r_hold_cnt <= '0;
                                r_state    <= ST_RPT;
                            end else begin
                                r_hold_cnt <= r_hold_cnt + c_HOLD_W'(1);
                            end
                        end
                    end
                    ST_RPT: begin
                        if (i_tick) begin
                            if (r_hold_cnt == c_RPT_LAST) begin
                                r_repeat   <= 1'b1;
                                r_hold_cnt <= '0;
                            end else begin
                                r_hold_cnt <= r_hold_cnt + c_HOLD_W'(1);
                            end
                        end
                    end
                    default: begin
                        r_state    <= ST_IDLE;
                        r_hold_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_repeat  = r_repeat;

endmodule
`default_nettype wire

// File: rtl/key_debounce_array.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce_array
//  Description : Multi-channel key debouncer with a shared tick prescaler,
//                per-key press/release/repeat pulses and a registered any-key
//                flag.
//  Ports       : clk, rst_n      clock, async active-low reset
//                i_keys_raw      raw asynchronous key pins
//                i_repeat_en     enables hold-to-repeat on all channels
//                o_keys_level    debounced levels, 1 = pressed
//                o_key_press     1-cycle pulses on debounced 0->1
//                o_key_release   1-cycle pulses on debounced 1->0
//                o_key_repeat    1-cycle pulses per repeat interval while held
//                o_any_key       registered OR of o_keys_level
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce_array
    import piano_cfg_pkg::*;
#(
    parameter int NUM_KEYS       = NUM_KEYS_DEFAULT,
    parameter int TICK_DIV       = TICK_DIV_1MS,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int HOLD_TICKS     = 500,
    parameter int REPEAT_TICKS   = 100,
    parameter bit ACTIVE_LOW     = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] i_keys_raw,
    input  logic                i_repeat_en,
    output logic [NUM_KEYS-1:0] o_keys_level,
    output logic [NUM_KEYS-1:0] o_key_press,
    output logic [NUM_KEYS-1:0] o_key_release,
    output logic [NUM_KEYS-1:0] o_key_repeat,
    output logic                o_any_key
);

    localparam int            c_PS_W    = cnt_width(TICK_DIV);
    localparam logic [c_PS_W-1:0] c_PS_LAST = c_PS_W'(TICK_DIV - 1);

    logic [c_PS_W-1:0]   r_ps_cnt;
    logic                r_tick;
    logic                r_any_key;
    logic [NUM_KEYS-1:0] w_level;

    // Tick is registered: it is high for the one cycle in which the
    // prescaler count sits at 0 after wrapping. With TICK_DIV=1 the count
    // is stuck at 0 and the tick is high every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ps_cnt <= '0;
            r_tick   <= 1'b0;
        end else if (r_ps_cnt == c_PS_LAST) begin
            r_ps_cnt <= '0;
            r_tick   <= 1'b1;
        end else begin
            r_ps_cnt <= r_ps_cnt + c_PS_W'(1);
            r_tick   <= 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_chan
            key_debounce_chan #(
                .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
                .HOLD_TICKS     (HOLD_TICKS),
                .REPEAT_TICKS   (REPEAT_TICKS),
                .ACTIVE_LOW     (ACTIVE_LOW)
            ) u_chan (
                .clk         (clk),
                .rst_n       (rst_n),
                .i_key_raw   (i_keys_raw[gi]),
                .i_tick      (r_tick),
                .i_repeat_en (i_repeat_en),
                .o_level     (w_level[gi]),
                .o_press     (o_key_press[gi]),
                .o_release   (o_key_release[gi]),
                .o_repeat    (o_key_repeat[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_any_key <= 1'b0;
        end else begin
            r_any_key <= |w_level;
        end
    end

    assign o_keys_level = w_level;
    assign o_any_key    = r_any_key;

endmodule
`default_nettype wire

// File: tb/tb_key_debounce_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_debounce_array
//  Description : Self-checking bench for key_debounce_array. Two instances
//                (active-high and active-low pins, driven with complementary
//                raw values) are compared every cycle against a tick-count
//                reference model, plus directed scenario checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_debounce_array;

    localparam int NK = 4;
    localparam int TD = 4;
    localparam int DB = 3;
    localparam int HT = 5;
    localparam int RT = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NK-1:0] raw;
    logic [NK-1:0] al_raw;
    logic          ren;
    logic [NK-1:0] lvl, prs, rel, rpt;
    logic          anyk;
    logic [NK-1:0] al_lvl, al_prs, al_rel, al_rpt;
    logic          al_any;

    assign al_raw = ~raw;

    always #5 clk = ~clk;

    key_debounce_array #(
        .NUM_KEYS(NK), .TICK_DIV(TD), .DEBOUNCE_TICKS(DB),
        .HOLD_TICKS(HT), .REPEAT_TICKS(RT), .ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_keys_raw(raw), .i_repeat_en(ren),
        .o_keys_level(lvl), .o_key_press(prs), .o_key_release(rel),
        .o_key_repeat(rpt), .o_any_key(anyk)
    );

    key_debounce_array #(
        .NUM_KEYS(NK), .TICK_DIV(TD), .DEBOUNCE_TICKS(DB),
        .HOLD_TICKS(HT), .REPEAT_TICKS(RT), .ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk(clk), .rst_n(rst_n), .i_keys_raw(al_raw), .i_repeat_en(ren),
        .o_keys_level(al_lvl), .o_key_press(al_prs), .o_key_release(al_rel),
        .o_key_repeat(al_rpt), .o_any_key(al_any)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: edges since reset, ticks since reset, raw history,
    // mismatch tick runs and the tick number of each armed press.
    int            m_edges;
    int            m_ticks;
    logic [NK-1:0] m_h1, m_h2;
    logic [NK-1:0] m_level, m_press, m_release, m_repeat;
    logic          m_any;
    int            m_mis   [NK];
    bit            m_armed [NK];
    int            m_ptick [NK];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_edges = 0; m_ticks = 0;
        m_h1 = '0; m_h2 = '0;
        m_level = '0; m_press = '0; m_release = '0; m_repeat = '0;
        m_any = 1'b0;
        for (int k = 0; k < NK; k++) begin
            m_mis[k] = 0; m_armed[k] = 1'b0; m_ptick[k] = 0;
        end
    endtask

    task automatic model_step();
        logic          tick;
        logic [NK-1:0] sync_v;
        int            el;
        m_edges++;
        // The channels see the first tick TD+1 edges after reset, then every TD.
        tick = (m_edges > TD) && (((m_edges - 1) % TD) == 0);
        if (tick) m_ticks++;
        sync_v = m_h2;
        m_h2   = m_h1;
        m_h1   = raw;
        m_any  = |m_level;
        m_press = '0; m_release = '0; m_repeat = '0;
        for (int k = 0; k < NK; k++) begin
            if (sync_v[k] == m_level[k]) begin
                m_mis[k] = 0;
            end else if (tick) begin
                m_mis[k]++;
                if (m_mis[k] == DB) begin
                    m_press[k]   = ~m_level[k];
                    m_release[k] =  m_level[k];
                    m_level[k]   = ~m_level[k];
                    m_mis[k]     = 0;
                end
            end
            if (!ren || m_release[k]) begin
                m_armed[k] = 1'b0;
            end else if (m_armed[k] && tick) begin
                el = m_ticks - m_ptick[k];
                if (el >= HT && ((el - HT) % RT) == 0) m_repeat[k] = 1'b1;
            end
            if (m_press[k] && ren) begin
                m_armed[k] = 1'b1;
                m_ptick[k] = m_ticks;
            end
        end
    endtask

    task automatic check_all();
        chk("level",      32'(lvl),    32'(m_level));
        chk("press",      32'(prs),    32'(m_press));
        chk("release",    32'(rel),    32'(m_release));
        chk("repeat",     32'(rpt),    32'(m_repeat));
        chk("any_key",    32'(anyk),   32'(m_any));
        chk("al_level",   32'(al_lvl), 32'(m_level));
        chk("al_press",   32'(al_prs), 32'(m_press));
        chk("al_release", 32'(al_rel), 32'(m_release));
        chk("al_repeat",  32'(al_rpt), 32'(m_repeat));
        chk("al_any_key", 32'(al_any), 32'(m_any));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        else       model_reset();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int lat, lat3, np, nr, nb, seen;
        int hold_left [NK];

        // Reset state
        rst_n = 1'b0; raw = '0; ren = 1'b0;
        model_reset();
        repeat (3) cycle();
        chk("reset_level", 32'(lvl), 32'h0);
        rst_n = 1'b1;

        // Active-low instance with pins idling high: no press.
        repeat (20) cycle();
        chk("al_idle_level", 32'(al_lvl), 32'h0);

        // 1. Clean press on key0
        raw[0] = 1'b1; lat = -1; np = 0;
        for (int i = 1; i <= 24; i++) begin
            cycle();
            if (prs[0]) np++;
            if (lat < 0 && lvl[0]) lat = i;
        end
        chk("t1_latency_le15", 32'(lat >= 1 && lat <= 15), 32'h1);
        chk("t1_press_count", 32'(np), 32'd1);

        // 2. Bounce on key1, then settle high
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) raw[1] = ~raw[1];
            cycle();
            if (lvl[1] || prs[1]) nb++;
        end
        chk("t2_no_change_bounce", 32'(nb), 32'd0);
        raw[1] = 1'b1; np = 0;
        repeat (30) begin cycle(); if (prs[1]) np++; end
        chk("t2_press_count", 32'(np), 32'd1);
        chk("t2_level", 32'(lvl[1]), 32'h1);

        // 3. Hold-to-repeat on key2
        ren = 1'b1; raw[2] = 1'b1; nr = 0; nb = 0;
        repeat (240) begin
            cycle();
            if (rpt[2]) nr++;
            if (rpt[2] && prs[2]) nb++;
        end
        chk("t3_repeat_many", 32'(nr >= 20), 32'h1);
        chk("t3_repeat_not_on_press", 32'(nb), 32'd0);
        ren = 1'b0; nr = 0;
        repeat (20) begin cycle(); if (rpt[2]) nr++; end
        chk("t3_repeat_stops", 32'(nr), 32'd0);

        // 4. Release key2 with repeat re-enabled: nothing restarts.
        ren = 1'b1; raw[2] = 1'b0; np = 0; nr = 0;
        repeat (30) begin cycle(); if (rel[2]) np++; if (rpt[2]) nr++; end
        chk("t4_release_count", 32'(np), 32'd1);
        chk("t4_no_repeat", 32'(nr), 32'd0);
        chk("t4_level", 32'(lvl[2]), 32'h0);

        // 5. Simultaneous press of keys 0 and 3
        ren = 1'b0; raw[0] = 1'b0;
        repeat (20) cycle();
        raw[0] = 1'b1; raw[3] = 1'b1; lat = -1; lat3 = -1; nb = 0;
        for (int i = 1; i <= 24; i++) begin
            cycle();
            if (lat  < 0 && prs[0]) lat  = i;
            if (lat3 < 0 && prs[3]) lat3 = i;
            if (rel[1] || prs[1] || prs[2] || rel[2]) nb++;
        end
        chk("t5_press_seen", 32'(lat > 0), 32'h1);
        chk("t5_same_cycle", 32'(lat3), 32'(lat));
        chk("t5_others_quiet", 32'(nb), 32'd0);

        // 6. Reset mid-count with key2 in repeat and key1 mid-debounce
        raw[0] = 1'b0; raw[3] = 1'b0; ren = 1'b1;
        repeat (20) cycle();
        raw[2] = 1'b1; seen = 0;
        repeat (40) begin cycle(); if (rpt[2]) seen = 1; end
        chk("t6_in_repeat", 32'(seen), 32'h1);
        raw[1] = 1'b0;
        for (int i = 0; i < 16 && m_mis[1] != 2; i++) cycle();
        chk("t6_key1_still_high", 32'(lvl[1]), 32'h1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_async_level", 32'(lvl), 32'h0);
        chk("t6_async_any", 32'(anyk), 32'h0);
        chk("t6_async_al_level", 32'(al_lvl), 32'h0);
        repeat (3) cycle();
        rst_n = 1'b1; lat = -1;
        for (int i = 1; i <= 30; i++) begin
            cycle();
            if (lat < 0 && prs[2]) lat = i;
        end
        chk("t6_full_debounce_after_reset", 32'(lat), 32'd13);

        // Random stimulus against the model
        for (int k = 0; k < NK; k++) hold_left[k] = 0;
        repeat (800) begin
            for (int k = 0; k < NK; k++) begin
                if (hold_left[k] == 0) begin
                    raw[k]       = 1'($urandom_range(0, 1));
                    hold_left[k] = int'($urandom_range(1, 24));
                end else begin
                    hold_left[k]--;
                end
            end
            if ($urandom_range(0, 99) == 0) ren = ~ren;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
